// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - round-robin scheduler sharing one opcode ALU between two requesters
// Holds ALU operands between ops and registers the result after a settle interval.
module alu_req_scheduler #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [5:0]          req_co,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [2:0]          alu_co,
  input  logic [RES_W-1:0]    alu_q,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RES_W-1:0]    rsp_q,
  output logic                rsp_id,
  output logic                rsp_err,
  output logic                busy
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_rr_ptr;
  logic [3:0]          r_cnt;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [2:0]          r_alu_co;
  logic [RES_W-1:0]    r_rsp_q;
  logic                r_rsp_id;
  logic                r_rsp_err;
  logic [1:0]          w_grant;
  logic                w_xfer;
  logic                w_id;
  logic [2:0]          w_co;
  logic                w_legal;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;

  // On a tie the pointer picks the winner; otherwise the lone requester wins.
  always_comb begin
    w_grant = req_valid;
    if (req_valid == 2'b11) w_grant = r_rr_ptr ? 2'b10 : 2'b01;
  end

  assign req_ready = (r_state == S_IDLE) ? w_grant : 2'b00;
  assign w_xfer    = |req_ready;
  assign w_id      = req_ready[1];
  assign w_co      = w_id ? req_co[5:3] : req_co[2:0];
  assign w_a       = w_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
  assign w_b       = w_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
  assign w_legal   = (w_co != 3'b000) && (w_co <= 3'b101);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = w_legal ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Undefined opcodes never reach the ALU: operands only move on a legal transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr  <= 1'b0;
      r_cnt     <= 4'd0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_co  <= 3'b000;
      r_rsp_q   <= '0;
      r_rsp_id  <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_rr_ptr <= ~w_id;
            r_rsp_id <= w_id;
            if (w_legal) begin
              r_alu_a  <= w_a;
              r_alu_b  <= w_b;
              r_alu_co <= w_co;
              r_cnt    <= CNT_INIT;
            end else begin
              r_rsp_q   <= '0;
              r_rsp_err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_q   <= alu_q;
            r_rsp_err <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_co    = r_alu_co;
  assign rsp_q     = r_rsp_q;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - scoreboard bench for alu_req_scheduler
// Main instance uses SETTLE=1; a second instance with SETTLE=4 covers reset during WAIT.
module tb_alu_req_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rsp_ready, rsp_valid, rsp_id, rsp_err, busy;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b, alu_q, rsp_q;
  logic [5:0]  req_co;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_co;

  logic        d4_rst_n, d4_rsp_ready, d4_rsp_valid, d4_rsp_id, d4_rsp_err, d4_busy;
  logic [1:0]  d4_req_valid, d4_req_ready;
  logic [15:0] d4_req_a, d4_req_b, d4_alu_q, d4_rsp_q;
  logic [5:0]  d4_req_co;
  logic [7:0]  d4_alu_a, d4_alu_b;
  logic [2:0]  d4_alu_co;

  typedef struct packed {logic id; logic [15:0] q; logic err;} exp_t;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_rr = 1'b0;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] co);
    case (co)
      3'b001:  return {15'd0, a[0]};
      3'b010:  return 16'(a) << 5;
      3'b011:  return 16'(a) * 16'd55 + 16'(b);
      3'b100:  return (a < b) ? 16'(a) : 16'(b);
      3'b101:  return 16'({1'b0, a} + {1'b0, b}) << 9;
      default: return 16'd0;
    endcase
  endfunction

  assign alu_q    = alu_f(alu_a, alu_b, alu_co);
  assign d4_alu_q = alu_f(d4_alu_a, d4_alu_b, d4_alu_co);

  alu_req_scheduler #(.DATA_W(8), .RES_W(16), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_co(req_co),
    .alu_a(alu_a), .alu_b(alu_b), .alu_co(alu_co), .alu_q(alu_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  alu_req_scheduler #(.DATA_W(8), .RES_W(16), .SETTLE(4)) u_dut4 (
    .clk(clk), .rst_n(d4_rst_n), .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req_a(d4_req_a), .req_b(d4_req_b), .req_co(d4_req_co),
    .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_co(d4_alu_co), .alu_q(d4_alu_q),
    .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_q(d4_rsp_q),
    .rsp_id(d4_rsp_id), .rsp_err(d4_rsp_err), .busy(d4_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the oldest expectation at each response handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_q), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_q", 32'(rsp_q), 32'(e.q));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] co, input logic [15:0] eq, input logic eerr);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    req_valid[id] = 1'b1;
    if (id) begin req_a[15:8] = a; req_b[15:8] = b; req_co[5:3] = co; end
    else    begin req_a[7:0]  = a; req_b[7:0]  = b; req_co[2:0] = co; end
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[id] && n < 50);
    chk("grant", 32'(req_ready[id]), 32'd1);
    e = '{id: id, q: eq, err: eerr};
    sb.push_back(e);
    exp_rr = ~id;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   n, n_gr;
    logic id;
    exp_t e;
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 2'b00; req_a = '0; req_b = '0; req_co = '0;
    d4_rst_n = 1'b0; d4_rsp_ready = 1'b1; d4_req_valid = 2'b00; d4_req_a = '0; d4_req_b = '0; d4_req_co = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_alu", 32'({alu_a, alu_b, alu_co}), 32'd0);
    chk("reset_rsp", 32'({rsp_valid, rsp_q, rsp_id, rsp_err, busy, req_ready}), 32'd0);
    rst_n = 1'b1; d4_rst_n = 1'b1;

    // Test 1: (3+4)<<9, one wait cycle
    send(1'b0, 8'd3, 8'd4, 3'b101, 16'h0E00, 1'b0);
    @(negedge clk);
    chk("t1_alu_co", 32'(alu_co), 32'b101);
    chk("t1_wait_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Test 2: remaining opcodes from requester 1
    send(1'b1, 8'd2, 8'd5, 3'b011, 16'd115, 1'b0);
    send(1'b1, 8'd9, 8'd4, 3'b100, 16'd4, 1'b0);
    send(1'b1, 8'hFF, 8'd0, 3'b010, 16'h1FE0, 1'b0);
    send(1'b1, 8'd7, 8'd0, 3'b001, 16'd1, 1'b0);
    drain();

    // Test 3: both requesters held valid, alternating grants
    @(posedge clk); #1;
    req_a = {8'd2, 8'd9}; req_b = {8'd5, 8'd4}; req_co = {3'b011, 3'b100}; req_valid = 2'b11;
    n = 0; n_gr = 0;
    while (n_gr < 8 && n < 200) begin
      @(negedge clk); n++;
      chk("ready_onehot", 32'(req_ready != 2'b11), 32'd1);
      if (req_ready != 2'b00) begin
        chk("rr_order", 32'(req_ready), exp_rr ? 32'b10 : 32'b01);
        id = req_ready[1];
        e  = id ? '{id: 1'b1, q: 16'd115, err: 1'b0} : '{id: 1'b0, q: 16'd4, err: 1'b0};
        sb.push_back(e);
        exp_rr = ~id;
        n_gr++;
      end
    end
    chk("tie_grants", 32'(n_gr), 32'd8);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drain();

    // Test 4: undefined opcode rejected, ALU operands untouched
    send(1'b1, 8'd2, 8'd5, 3'b011, 16'd115, 1'b0);
    drain();
    send(1'b0, 8'd1, 8'd1, 3'b110, 16'd0, 1'b1);
    @(negedge clk);
    chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t4_alu_co", 32'(alu_co), 32'b011);
    chk("t4_alu_a", 32'(alu_a), 32'd2);
    drain();

    // Test 5: consumer stalls for 5 cycles
    rsp_ready = 1'b0;
    send(1'b0, 8'd9, 8'd4, 3'b100, 16'd4, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    req_a[15:8] = 8'd1; req_co[5:3] = 3'b001; req_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold", 32'({rsp_valid, rsp_q, rsp_id, busy}), 32'({1'b1, 16'd4, 1'b0, 1'b1}));
      chk("t5_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_idle", 32'({busy, rsp_valid}), 32'd0);
    drain();

    // Test 6: reset during WAIT on the SETTLE=4 instance
    @(posedge clk); #1;
    d4_req_a = {8'd0, 8'd3}; d4_req_b = {8'd0, 8'd4}; d4_req_co = {3'b000, 3'b101}; d4_req_valid = 2'b01;
    @(negedge clk);
    chk("t6_ready", 32'(d4_req_ready), 32'b01);
    @(posedge clk); #1;
    d4_req_valid = 2'b00;
    @(negedge clk);
    chk("t6_busy", 32'({d4_busy, d4_rsp_valid}), 32'b10);
    d4_rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_reset_alu", 32'({d4_alu_a, d4_alu_b, d4_alu_co}), 32'd0);
    chk("t6_reset_rsp", 32'({d4_rsp_valid, d4_rsp_q, d4_rsp_id, d4_rsp_err, d4_busy, d4_req_ready}), 32'd0);
    d4_rst_n = 1'b1;
    @(posedge clk); #1;
    d4_req_a = {8'd0, 8'd9}; d4_req_b = {8'd0, 8'd4}; d4_req_co = {3'b000, 3'b100}; d4_req_valid = 2'b01;
    @(negedge clk);
    chk("t6_ready2", 32'(d4_req_ready), 32'b01);
    @(posedge clk); #1;
    d4_req_valid = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (!d4_rsp_valid && n < 20);
    chk("t6_latency", 32'(n), 32'd5);
    chk("t6_rsp", 32'({d4_rsp_q, d4_rsp_id, d4_rsp_err}), 32'({16'd4, 1'b0, 1'b0}));
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
